time_keeper: RTL
================

TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 Parameters: none; all widths and limits fixed (24 h clock, BCD).
REQ-002 clk  in  1  system clock; all logic on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 tick_in  in  1  slow square wave from the clock divider (divided_clk), asynchronous to logic use; rising edge = one second.
REQ-005 set_valid  in  1  set request; set_hour/set_min held stable while high.
REQ-006 set_hour  in  6  BCD hour {tens[5:4], ones[3:0]}.
REQ-007 set_min  in  7  BCD minute {tens[6:4], ones[3:0]}.
REQ-008 set_ready  out  1  block can accept a set this cycle.
REQ-009 set_err  out  1  one-cycle pulse: offered set value out of range.
REQ-010 hour_bcd  out  6  current hour, same packing as set_hour.
REQ-011 min_bcd  out  7  current minute, same packing as set_min.
REQ-012 sec_bcd  out  7  current second {tens[6:4], ones[3:0]}.
REQ-013 sec_tick  out  1  one-cycle pulse on each detected tick_in rising edge.
REQ-014 day_tick  out  1  one-cycle pulse when time wraps 23:59:59 -> 00:00:00.

Function
REQ-015 tick_in SHALL pass a 3-flop chain (s1,s2,s3); sec_tick = s2 & ~s3, combinational from registers.
REQ-016 A tick_in first sampled high at edge k SHALL give sec_tick high between edges k+1 and k+2; time outputs SHALL change at edge k+2.
REQ-017 A tick_in high for any number of cycles SHALL produce exactly one sec_tick; falling edges SHALL produce none.
REQ-018 On sec_tick the time SHALL advance one second in BCD: ones digit 9 -> 0 with tens carry; seconds 59 -> 00 carries to minutes; minutes 59 -> 00 carries to hours; hours 23 -> 00.
REQ-019 day_tick SHALL assert in the same cycle as the sec_tick that wraps 23:59:59 to 00:00:00, and at no other time.
REQ-020 No BCD digit SHALL ever hold a value above 9; hour tens never above 2; minute/second tens never above 5.
REQ-021 set_ready SHALL be ~sec_tick & ~reset; a set is accepted only when set_valid & set_ready.
REQ-022 An accepted set with valid value (hour <= 23, minute <= 59, each digit legal BCD) SHALL load hour/min and clear seconds to 00 at that edge; sec_tick SHALL not advance time in that cycle.
REQ-023 An accepted set with an invalid value SHALL leave time unchanged and pulse set_err high in the following cycle.
REQ-024 set_valid held high over several ready cycles SHALL be accepted every such cycle (level-sensitive; no edge detect).
REQ-025 When set_valid is high during a sec_tick cycle, the tick SHALL win; the set SHALL be accepted in the next ready cycle.

Reset
REQ-026 reset SHALL clear s1..s3, time to 00:00:00, set_err, day_tick and sec_tick to 0.
REQ-027 reset asserted mid-operation SHALL discard any in-flight tick edge; a tick_in already high at reset release SHALL NOT produce a sec_tick until it goes low and high again.
REQ-028 set_ready SHALL be 0 while reset is high and 1 in the first cycle after release.

Configuration
REQ-029 Macro TIME_KEEPER_ALARM_EN SHALL, when defined, add inputs alarm_hour (6, BCD), alarm_min (7, BCD), alarm_arm (1) and output alarm (1).
REQ-030 With TIME_KEEPER_ALARM_EN: alarm SHALL pulse one cycle, one cycle after time becomes alarm_hour:alarm_min:00 via sec_tick while alarm_arm=1; a set never triggers it; reset clears it.
REQ-031 Without TIME_KEEPER_ALARM_EN the alarm ports and logic SHALL not exist; all other behaviour is identical.

Verification
REQ-032 Reset, tick_in held low 100 cycles -> time 00:00:00, sec_tick never high, set_ready=1.
REQ-033 tick_in high 50 cycles then low, 3 times -> exactly 3 sec_tick pulses, each 2 cycles after first high sample; sec_bcd=7'h03.
REQ-034 Set 23:59 accepted, then 59 ticks then one more -> 23:59:59, then 00:00:00 with day_tick one cycle.
REQ-035 Set hour 6'h24, and separately minute 7'h5A -> set_err pulses, time unchanged; set_valid coincident with sec_tick -> set_ready=0, set applied next cycle, seconds 00.
REQ-036 tick_in high during reset, released with it high -> no sec_tick until a new low->high transition.
REQ-037 (TIME_KEEPER_ALARM_EN) arm 07:30, set 07:29, 60 ticks -> alarm one pulse at 07:30:00; alarm_arm=0 -> no pulse.

Source files
------------

// File: rtl/time_keeper.sv
// time_keeper: 24 h BCD time-of-day counter advanced by a synchronised one-second tick.
// Defining TIME_KEEPER_ALARM_EN adds an hour:minute alarm comparator.
module time_keeper (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       set_valid,
    input  logic [5:0] set_hour,
    input  logic [6:0] set_min,
`ifdef TIME_KEEPER_ALARM_EN
    input  logic [5:0] alarm_hour,
    input  logic [6:0] alarm_min,
    input  logic       alarm_arm,
    output logic       alarm,
`endif
    output logic       set_ready,
    output logic       set_err,
    output logic [5:0] hour_bcd,
    output logic [6:0] min_bcd,
    output logic [6:0] sec_bcd,
    output logic       sec_tick,
    output logic       day_tick
);
    logic       s1, s2, s3, live, armed;
    logic [1:0] hr_t, hr_t_n;
    logic [3:0] hr_o, hr_o_n;
    logic [2:0] mn_t, mn_t_n;
    logic [3:0] mn_o, mn_o_n;
    logic [2:0] sc_t, sc_t_n;
    logic [3:0] sc_o, sc_o_n;
    logic       accept, set_ok, last_second;

    // armed: a rise only counts once a genuine low sample has been seen since reset,
    // so a tick_in already high at reset release cannot fire.
    assign sec_tick  = s2 & ~s3 & armed;
    assign set_ready = ~sec_tick & ~reset;
    assign accept    = set_valid & set_ready;
    assign set_ok    = (set_hour[3:0] <= 4'd9) &&
                       ((set_hour[5:4] < 2'd2) || (set_hour[5:4] == 2'd2 && set_hour[3:0] <= 4'd3)) &&
                       (set_min[3:0] <= 4'd9) && (set_min[6:4] <= 3'd5);
    assign last_second = (hr_t == 2'd2) && (hr_o == 4'd3) && (mn_t == 3'd5) &&
                         (mn_o == 4'd9) && (sc_t == 3'd5) && (sc_o == 4'd9);
    assign day_tick  = sec_tick & last_second;
    assign hour_bcd  = {hr_t, hr_o};
    assign min_bcd   = {mn_t, mn_o};
    assign sec_bcd   = {sc_t, sc_o};

    always_comb begin
        sc_o_n = sc_o + 4'd1;
        sc_t_n = sc_t;
        mn_o_n = mn_o;
        mn_t_n = mn_t;
        hr_o_n = hr_o;
        hr_t_n = hr_t;
        if (sc_o == 4'd9) begin
            sc_o_n = '0;
            sc_t_n = sc_t + 3'd1;
            if (sc_t == 3'd5) begin
                sc_t_n = '0;
                mn_o_n = mn_o + 4'd1;
                if (mn_o == 4'd9) begin
                    mn_o_n = '0;
                    mn_t_n = mn_t + 3'd1;
                    if (mn_t == 3'd5) begin
                        mn_t_n = '0;
                        if (hr_t == 2'd2 && hr_o == 4'd3) begin
                            hr_t_n = '0;
                            hr_o_n = '0;
                        end else if (hr_o == 4'd9) begin
                            hr_o_n = '0;
                            hr_t_n = hr_t + 2'd1;
                        end else begin
                            hr_o_n = hr_o + 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            live    <= 1'b0;
            armed   <= 1'b0;
            set_err <= 1'b0;
            hr_t    <= '0;
            hr_o    <= '0;
            mn_t    <= '0;
            mn_o    <= '0;
            sc_t    <= '0;
            sc_o    <= '0;
        end else begin
            s1      <= tick_in;
            s2      <= s1;
            s3      <= s2;
            live    <= 1'b1;
            armed   <= armed | (live & ~s1);
            set_err <= accept & ~set_ok;
            if (accept && set_ok) begin
                hr_t <= set_hour[5:4];
                hr_o <= set_hour[3:0];
                mn_t <= set_min[6:4];
                mn_o <= set_min[3:0];
                sc_t <= '0;
                sc_o <= '0;
            end else if (sec_tick) begin
                hr_t <= hr_t_n;
                hr_o <= hr_o_n;
                mn_t <= mn_t_n;
                mn_o <= mn_o_n;
                sc_t <= sc_t_n;
                sc_o <= sc_o_n;
            end
        end
    end

`ifdef TIME_KEEPER_ALARM_EN
    logic ticked;

    // ticked marks that the time now shown arrived by a second tick, not by a set.
    always_ff @(posedge clk) begin
        if (reset) begin
            ticked <= 1'b0;
            alarm  <= 1'b0;
        end else begin
            ticked <= sec_tick;
            alarm  <= ticked && alarm_arm && ({hr_t, hr_o} == alarm_hour) &&
                      ({mn_t, mn_o} == alarm_min) && (sc_t == 3'd0) && (sc_o == 4'd0);
        end
    end
`endif
endmodule
